// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART byte transmitter between two requesters (0 = CPU register
//   path, 1 = monitor/debug source). Round-robin at message granularity: the
//   granted requester holds the transmitter until it sends a byte flagged
//   last. A lock timeout force-releases an owner whose valid stays low for
//   LOCK_TIMEOUT consecutive cycles.
//
//   Ports
//     clk, rst_n                  clock, asynchronous active-low reset
//     reqN_data/valid/last        requester N byte, valid, end-of-message
//     reqN_ready                  requester N byte accepted this cycle
//     tx_data/tx_data_valid       byte offered to the transmitter
//     tx_data_ready               transmitter accepts (transfer = valid & ready)
//     grant                       one-hot owner, 00 when idle
//     busy                        lock held
//     timeout_evt                 one-cycle pulse on forced release
//     stat_bytes0/1, stat_timeouts  statistics (zero unless enabled)
//
//   Build option: define UART_TX_ARB_STATS_EN to instantiate the statistics
//   counters; otherwise the stat ports are tied to zero.

module uart_tx_arbiter #(
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned TO_W         = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  req0_data,
  input  logic        req0_valid,
  input  logic        req0_last,
  output logic        req0_ready,
  input  logic [7:0]  req1_data,
  input  logic        req1_valid,
  input  logic        req1_last,
  output logic        req1_ready,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_evt,
  output logic [15:0] stat_bytes0,
  output logic [15:0] stat_bytes1,
  output logic [7:0]  stat_timeouts
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  // Count value on the last tolerated idle cycle; release happens when the
  // counter would reach LOCK_TIMEOUT.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);

  logic            state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            rr_q, rr_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            evt_q, evt_d;

  logic       locked;
  logic       own1;
  logic       own_valid;
  logic       own_last;
  logic       xfer;
  logic       pick1;

  assign locked    = (state_q == ST_LOCKED);
  assign own1      = grant_q[1];
  assign own_valid = own1 ? req1_valid : req0_valid;
  assign own_last  = own1 ? req1_last  : req0_last;

  assign tx_data_valid = locked & own_valid;
  assign tx_data       = locked ? (own1 ? req1_data : req0_data) : '0;
  assign xfer          = tx_data_valid & tx_data_ready;
  assign req0_ready    = xfer & grant_q[0];
  assign req1_ready    = xfer & grant_q[1];

  assign grant       = grant_q;
  assign busy        = locked;
  assign timeout_evt = evt_q;

  // Requester 1 wins in IDLE when it is alone or when both ask and the
  // pointer favours it.
  assign pick1 = req1_valid & (~req0_valid | rr_q);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    to_cnt_d = to_cnt_q;
    evt_d    = 1'b0;
    if (!locked) begin
      to_cnt_d = '0;
      if (req0_valid | req1_valid) begin
        state_d = ST_LOCKED;
        grant_d = pick1 ? 2'b10 : 2'b01;
      end
    end else if (own_valid) begin
      // An offered byte is never an owner stall, so the timeout cannot fire
      // on a transfer cycle.
      to_cnt_d = '0;
      if (xfer && own_last) begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
        rr_d    = ~own1;
      end
    end else if (to_cnt_q == TO_LAST) begin
      state_d  = ST_IDLE;
      grant_d  = 2'b00;
      rr_d     = ~own1;
      to_cnt_d = '0;
      evt_d    = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= 2'b00;
      rr_q     <= 1'b0;
      to_cnt_q <= '0;
      evt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      to_cnt_q <= to_cnt_d;
      evt_q    <= evt_d;
    end
  end

`ifdef UART_TX_ARB_STATS_EN
  logic [15:0] b0_q, b1_q;
  logic [7:0]  to_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b0_q <= '0;
      b1_q <= '0;
      to_q <= '0;
    end else begin
      if (req0_ready) b0_q <= b0_q + 1'b1;
      if (req1_ready) b1_q <= b1_q + 1'b1;
      if (evt_q)      to_q <= to_q + 1'b1;
    end
  end

  assign stat_bytes0   = b0_q;
  assign stat_bytes1   = b1_q;
  assign stat_timeouts = to_q;
`else
  assign stat_bytes0   = '0;
  assign stat_bytes1   = '0;
  assign stat_timeouts = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (LOCK_TIMEOUT = 8).
// Requesters are driven from per-requester byte queues; a message-level
// reference model predicts every output each cycle.
module tb_uart_tx_arbiter;
  localparam int LT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req0_data, req1_data, tx_data;
  logic        req0_valid, req0_last, req0_ready;
  logic        req1_valid, req1_last, req1_ready;
  logic        tx_data_valid, tx_data_ready;
  logic [1:0]  grant;
  logic        busy, timeout_evt;
  logic [15:0] stat_bytes0, stat_bytes1;
  logic [7:0]  stat_timeouts;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.LOCK_TIMEOUT(LT), .TO_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
    .grant(grant), .busy(busy), .timeout_evt(timeout_evt),
    .stat_bytes0(stat_bytes0), .stat_bytes1(stat_bytes1), .stat_timeouts(stat_timeouts)
  );

  typedef struct {
    logic [7:0] d;
    logic       last;
    int         gap;   // cycles the requester stays silent after this byte
  } item_t;

  item_t q0[$], q1[$];
  bit    pres[2];
  int    hold[2];
  int    pprob = 100;
  int    txr_mode = 0;   // 0 fixed, 1 random, 2 pulse every 4th cycle
  bit    txr_fix = 1'b1;
  int    tick_no = 0;

  int          m_own = -1;
  int          m_rr = 0;
  int          m_stall = 0;
  bit          m_evt = 1'b0;
  logic [15:0] m_b0 = '0, m_b1 = '0;
  logic [7:0]  m_to = '0;

  logic [7:0] log_d[$];
  int         log_k[$], log_t[$], evt_ticks[$];
  logic [7:0] e_d[$];
  int         e_k[$];

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int k, input logic [7:0] d, input logic last, input int gap);
    item_t it;
    it.d = d; it.last = last; it.gap = gap;
    if (k == 0) q0.push_back(it); else q1.push_back(it);
  endtask

  task automatic clear_logs();
    log_d.delete(); log_k.delete(); log_t.delete(); evt_ticks.delete();
    e_d.delete(); e_k.delete();
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, log_d.size(), e_d.size());
    for (int i = 0; i < e_d.size() && i < log_d.size(); i++) begin
      chk({tag, "_data"}, log_d[i], e_d[i]);
      chk({tag, "_src"}, log_k[i], e_k[i]);
    end
  endtask

  task automatic tick();
    logic ov, ol, xf, ne;
    logic [7:0] od;
    item_t it;
    int nown;
    for (int k = 0; k < 2; k++)
      if (!pres[k] && hold[k] == 0 && qsize(k) > 0 && int'($urandom_range(99)) < pprob)
        pres[k] = 1'b1;
    if (q0.size() > 0) begin req0_data = q0[0].d; req0_last = q0[0].last; end
    else begin req0_data = 8'($urandom); req0_last = 1'($urandom); end
    if (q1.size() > 0) begin req1_data = q1[0].d; req1_last = q1[0].last; end
    else begin req1_data = 8'($urandom); req1_last = 1'($urandom); end
    req0_valid = pres[0];
    req1_valid = pres[1];
    case (txr_mode)
      0:       tx_data_ready = txr_fix;
      1:       tx_data_ready = 1'($urandom_range(1));
      default: tx_data_ready = (tick_no % 4 == 3);
    endcase
    #4;
    if (m_own == 0)      begin ov = req0_valid; od = req0_data; ol = req0_last; end
    else if (m_own == 1) begin ov = req1_valid; od = req1_data; ol = req1_last; end
    else                 begin ov = 1'b0; od = 8'h00; ol = 1'b0; end
    xf = ov & tx_data_ready;

    chk("grant", grant, (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10));
    chk("busy", busy, m_own >= 0);
    chk("tx_valid", tx_data_valid, ov);
    chk("tx_data", tx_data, od);
    chk("req0_ready", req0_ready, xf && m_own == 0);
    chk("req1_ready", req1_ready, xf && m_own == 1);
    chk("timeout_evt", timeout_evt, m_evt);
`ifdef UART_TX_ARB_STATS_EN
    chk("stat_b0", stat_bytes0, m_b0);
    chk("stat_b1", stat_bytes1, m_b1);
    chk("stat_to", stat_timeouts, m_to);
`else
    chk("stat_b0", stat_bytes0, 0);
    chk("stat_b1", stat_bytes1, 0);
    chk("stat_to", stat_timeouts, 0);
`endif

    if (tx_data_valid === 1'b1 && tx_data_ready === 1'b1) begin
      log_d.push_back(tx_data);
      log_k.push_back((grant === 2'b10) ? 1 : 0);
      log_t.push_back(tick_no);
    end
    if (timeout_evt === 1'b1) evt_ticks.push_back(tick_no);

    nown = m_own;
    ne = 1'b0;
    if (m_own < 0) begin
      if (req0_valid && req1_valid) nown = m_rr;
      else if (req0_valid) nown = 0;
      else if (req1_valid) nown = 1;
      m_stall = 0;
    end else if (ov) begin
      m_stall = 0;
      if (xf) begin
        if (m_own == 0) m_b0++; else m_b1++;
        if (ol) begin nown = -1; m_rr = 1 - m_own; end
      end
    end else begin
      m_stall++;
      if (m_stall == LT) begin
        nown = -1; m_rr = 1 - m_own; ne = 1'b1; m_to++; m_stall = 0;
      end
    end

    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) if (hold[k] > 0) hold[k]--;
    if (xf) begin
      if (m_own == 0) it = q0.pop_front(); else it = q1.pop_front();
      pres[m_own] = 1'b0;
      hold[m_own] = it.gap;
    end
    m_own = nown;
    m_evt = ne;
    tick_no++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int budget = 400;
    while ((q0.size() > 0 || q1.size() > 0 || m_own >= 0) && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain_pending", q0.size() + q1.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_valid", tx_data_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    chk("rst_evt", timeout_evt, 1'b0);
    chk("rst_stat_b0", stat_bytes0, 16'h0);
    chk("rst_stat_to", stat_timeouts, 8'h0);
    q0.delete(); q1.delete();
    pres[0] = 1'b0; pres[1] = 1'b0; hold[0] = 0; hold[1] = 0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    m_own = -1; m_rr = 0; m_stall = 0; m_evt = 1'b0;
    m_b0 = '0; m_b1 = '0; m_to = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_data = '0; req0_valid = 1'b0; req0_last = 1'b0;
    req1_data = '0; req1_valid = 1'b0; req1_last = 1'b0;
    tx_data_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Three-byte req0 message, transmitter ready every 4th cycle.
    clear_logs();
    txr_mode = 2;
    push(0, 8'h41, 1'b0, 0); push(0, 8'h42, 1'b0, 0); push(0, 8'h43, 1'b1, 0);
    drain();
    run(2);
    e_d = '{8'h41, 8'h42, 8'h43}; e_k = '{0, 0, 0};
    chk_log("t1");

    // Contention from reset: req0 message first, no interleave.
    do_reset();
    clear_logs();
    txr_mode = 0; txr_fix = 1'b1;
    push(0, 8'h10, 1'b0, 0); push(0, 8'h11, 1'b1, 0);
    push(1, 8'h20, 1'b0, 0); push(1, 8'h21, 1'b1, 0);
    drain();
    e_d = '{8'h10, 8'h11, 8'h20, 8'h21}; e_k = '{0, 0, 1, 1};
    chk_log("t2a");
    clear_logs();
    push(0, 8'h12, 1'b1, 0); push(1, 8'h22, 1'b1, 0);
    drain();
    e_d = '{8'h12, 8'h22}; e_k = '{0, 1};
    chk_log("t2b");

    // req1 stalls after its first byte; pending req0 taken after the timeout.
    clear_logs();
    push(1, 8'h30, 1'b0, 20); push(1, 8'h31, 1'b1, 0);
    run(3);
    push(0, 8'h40, 1'b0, 0); push(0, 8'h41, 1'b1, 0);
    drain();
    e_d = '{8'h30, 8'h40, 8'h41, 8'h31}; e_k = '{1, 0, 0, 1};
    chk_log("t3");
    chk("t3_evt_count", evt_ticks.size(), 1);
    if (evt_ticks.size() > 0 && log_t.size() > 0)
      chk("t3_evt_delay", evt_ticks[0] - log_t[0], 9);

    // Transfer lands on the threshold cycle: lock kept, no timeout.
    clear_logs();
    push(0, 8'h50, 1'b0, LT - 1); push(0, 8'h51, 1'b0, LT - 1); push(0, 8'h52, 1'b1, 0);
    drain();
    e_d = '{8'h50, 8'h51, 8'h52}; e_k = '{0, 0, 0};
    chk_log("t4");
    chk("t4_evt_count", evt_ticks.size(), 0);

    // Reset during byte 2 of a 4-byte message; pointer returns to req0.
    push(0, 8'h80, 1'b0, 0); push(0, 8'h81, 1'b0, 0);
    push(0, 8'h82, 1'b0, 0); push(0, 8'h83, 1'b1, 0);
    run(2);
    do_reset();
    clear_logs();
    push(1, 8'h70, 1'b1, 0);
    push(0, 8'h60, 1'b0, 0); push(0, 8'h61, 1'b1, 0);
    drain();
    e_d = '{8'h60, 8'h61, 8'h70}; e_k = '{0, 0, 1};
    chk_log("t5");

    // Statistics: 5 req0 bytes, 3 req1 bytes, 1 timeout since reset.
    push(0, 8'h62, 1'b0, 0); push(0, 8'h63, 1'b0, 0); push(0, 8'h64, 1'b1, 0);
    push(1, 8'h72, 1'b0, 12); push(1, 8'h73, 1'b1, 0);
    drain();
    run(2);
`ifdef UART_TX_ARB_STATS_EN
    chk("t6_b0", stat_bytes0, 16'd5);
    chk("t6_b1", stat_bytes1, 16'd3);
    chk("t6_to", stat_timeouts, 8'd1);
`else
    chk("t6_b0", stat_bytes0, 16'd0);
    chk("t6_b1", stat_bytes1, 16'd0);
    chk("t6_to", stat_timeouts, 8'd0);
`endif

    // Randomized traffic against the model.
    pprob = 60; txr_mode = 1;
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (qsize(k) < 2) begin
          int len = int'($urandom_range(1, 4));
          for (int j = 0; j < len; j++)
            push(k, 8'($urandom), j == len - 1,
                 ($urandom_range(9) == 0) ? int'($urandom_range(12)) : int'($urandom_range(2)));
        end
      end
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
